// File: rtl/fu_pkg.sv
// Shared definitions for the FU context sequencer: opcodes, context word layout, states.
package fu_pkg;

  localparam logic [3:0] PASS_A = 4'd0;
  localparam logic [3:0] PASS_B = 4'd1;
  localparam logic [3:0] ADD    = 4'd2;
  localparam logic [3:0] SUB    = 4'd3;
  localparam logic [3:0] MULT   = 4'd4;
  localparam logic [3:0] DIV    = 4'd5;
  localparam logic [3:0] AND    = 4'd6;
  localparam logic [3:0] OR     = 4'd7;
  localparam logic [3:0] MOD    = 4'd8;
  localparam logic [3:0] SHL    = 4'd9;
  localparam logic [3:0] SHR    = 4'd10;
  localparam logic [3:0] BEQ    = 4'd11;
  localparam logic [3:0] BNE    = 4'd12;
  localparam logic [3:0] SLT    = 4'd13;
  localparam logic [3:0] NOT    = 4'd14;
  localparam logic [3:0] MERGE  = 4'd15;

  // Bit offsets inside a context word; the target field occupies [TGT +: AW].
  localparam int OP   = 0;
  localparam int EN   = 4;
  localparam int BRC  = 5;
  localparam int LAST = 6;
  localparam int RSV  = 7;
  localparam int TGT  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BWAIT = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic       rsv;
    logic       last;
    logic       brc;
    logic       en;
    logic [3:0] op;
  } ctx_ctrl_t;

  function automatic ctx_ctrl_t ctx_ctrl(input logic [7:0] w);
    return ctx_ctrl_t'(w);
  endfunction

endpackage

// File: rtl/fu_ctx_mem.sv
// Context store: flop array with one synchronous write port and one asynchronous read port.
module fu_ctx_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // Contents deliberately survive rst_n so a program can be rerun after a reset.
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fu_seq.sv
// Context sequencer for one CGRA functional unit: issues a context per cycle,
// waits one bubble on branch contexts, and loops the program iters times.
module fu_seq
  import fu_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [8+AW-1:0]   cfg_data,
  input  logic              start,
  input  logic [ITER_W-1:0] iters,
  input  logic              abort,
  input  logic              fu_branch,
  output logic [3:0]        fu_op,
  output logic              fu_en,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     pc
);

  localparam int DW = 8 + AW;

  seq_state_e        state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic              done_q, done_d;

  logic [DW-1:0]     ctx_w;
  ctx_ctrl_t         w_ctrl;
  logic [AW-1:0]     w_tgt;
  logic              mem_we;

  // Result of the sequential (non-branch) step shared by RUN and a not-taken BWAIT.
  seq_state_e        adv_state;
  logic [AW-1:0]     adv_pc;
  logic [ITER_W-1:0] adv_iter;
  logic              adv_done;

  assign mem_we = cfg_we && (state_q == IDLE);

  fu_ctx_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ctx_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (pc_q),
    .rdata (ctx_w)
  );

  assign w_ctrl = ctx_ctrl(ctx_w[7:0]);
  assign w_tgt  = ctx_w[TGT +: AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      iter_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      iter_cnt_q <= iter_cnt_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    adv_state = RUN;
    adv_pc    = pc_q + AW'(1);
    adv_iter  = iter_cnt_q;
    adv_done  = 1'b0;
    if (w_ctrl.last) begin
      adv_pc = '0;
      if (iter_cnt_q == ITER_W'(1)) begin
        adv_state = IDLE;
        adv_done  = 1'b1;
      end else begin
        adv_iter = iter_cnt_q - ITER_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    iter_cnt_d = iter_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (iters != '0) begin
            pc_d       = '0;
            iter_cnt_d = iters;
            state_d    = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (w_ctrl.brc) begin
          state_d = BWAIT;
        end else begin
          state_d    = adv_state;
          pc_d       = adv_pc;
          iter_cnt_d = adv_iter;
          done_d     = adv_done;
        end
      end
      BWAIT: begin
        // A taken branch wins over last and leaves the iteration count alone.
        if (fu_branch) begin
          pc_d    = w_tgt;
          state_d = RUN;
        end else begin
          state_d    = adv_state;
          pc_d       = adv_pc;
          iter_cnt_d = adv_iter;
          done_d     = adv_done;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
    if (abort) begin
      state_d    = IDLE;
      pc_d       = '0;
      iter_cnt_d = iter_cnt_q;
      done_d     = 1'b0;
    end
  end

  always_comb begin
    fu_op = 4'd0;
    fu_en = 1'b0;
    case (state_q)
      RUN: begin
        fu_op = w_ctrl.op;
        fu_en = w_ctrl.en;
      end
      BWAIT: begin
        fu_op = w_ctrl.op;
      end
      default: begin
        fu_op = 4'd0;
        fu_en = 1'b0;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign pc   = pc_q;

  rsv_zero_on_write: assert property (@(posedge clk) disable iff (!rst_n)
    mem_we |-> !cfg_data[RSV]);

  rsv_zero_on_issue: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |-> !w_ctrl.rsv);

endmodule

// File: tb/tb_fu_seq.sv
// Scoreboard bench for fu_seq: stimulus queues the expected per-cycle trace,
// a negedge monitor pops and compares it against fu_en/fu_op/done/busy.
module tb_fu_seq;
  import fu_pkg::*;

  localparam int AW     = 4;
  localparam int DW     = 8 + AW;
  localparam int ITER_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [DW-1:0]     cfg_data = '0;
  logic              start = 1'b0;
  logic [ITER_W-1:0] iters = '0;
  logic              abort = 1'b0;
  logic              fu_branch = 1'b0;
  logic [3:0]        fu_op;
  logic              fu_en;
  logic              busy;
  logic              done;
  logic [AW-1:0]     pc;

  fu_seq #(.DEPTH(16), .AW(AW), .ITER_W(ITER_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .start     (start),
    .iters     (iters),
    .abort     (abort),
    .fu_branch (fu_branch),
    .fu_op     (fu_op),
    .fu_en     (fu_en),
    .busy      (busy),
    .done      (done),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       care;
    bit       en;
    bit [3:0] op;
    bit       dn;
    bit       bsy;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    errors = 0;
  int    checks = 0;
  int    cyc_idx = 0;
  string test_name = "reset";

  function automatic exp_t ex(bit care, bit en, bit [3:0] op, bit dn, bit bsy);
    exp_t e;
    e.care = care; e.en = en; e.op = op; e.dn = dn; e.bsy = bsy;
    return e;
  endfunction

  function automatic void push_issue(bit [3:0] op);  exp_q.push_back(ex(1, 1, op, 0, 1)); endfunction
  function automatic void push_bubble(bit [3:0] op); exp_q.push_back(ex(1, 0, op, 0, 1)); endfunction
  function automatic void push_done();               exp_q.push_back(ex(1, 0, 4'd0, 1, 0)); endfunction
  function automatic void push_idle();               exp_q.push_back(ex(1, 0, 4'd0, 0, 0)); endfunction
  function automatic void push_skip();               exp_q.push_back(ex(0, 0, 4'd0, 0, 0)); endfunction

  function automatic logic [DW-1:0] mk(logic [3:0] op, logic en, logic brc, logic last,
                                       logic [AW-1:0] tgt);
    logic [DW-1:0] w;
    w = '0;
    w[TGT +: AW] = tgt;
    w[LAST] = last;
    w[BRC]  = brc;
    w[EN]   = en;
    w[OP +: 4] = op;
    return w;
  endfunction

  // Monitor: one line per compared cycle, FAIL lines on mismatch.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      cyc_idx++;
      if (mon_e.care) begin
        checks++;
        if ({fu_en, fu_op, done, busy} !== {mon_e.en, mon_e.op, mon_e.dn, mon_e.bsy}) begin
          errors++;
          $display("FAIL %s cyc%0d: got en=%0b op=%0d done=%0b busy=%0b, want en=%0b op=%0d done=%0b busy=%0b",
                   test_name, cyc_idx, fu_en, fu_op, done, busy,
                   mon_e.en, mon_e.op, mon_e.dn, mon_e.bsy);
        end else begin
          $display("ok   %s cyc%0d: en=%0b op=%0d done=%0b busy=%0b",
                   test_name, cyc_idx, fu_en, fu_op, done, busy);
        end
      end
    end else if (rst_n && (fu_en || done)) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected output: en=%0b done=%0b, want both 0", test_name, fu_en, done);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wr(logic [AW-1:0] a, logic [DW-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic go(logic [ITER_W-1:0] n);
    start = 1'b1; iters = n;
    @(posedge clk); #1;
    start = 1'b0;
    cyc_idx = 0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() > 0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s drain timeout: %0d entries left, want 0", test_name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic load_prog1();
    wr(0, mk(ADD, 1, 0, 0, 0));
    wr(1, mk(SUB, 1, 0, 0, 0));
    wr(2, mk(AND, 1, 0, 0, 0));
    wr(3, mk(OR,  1, 0, 1, 0));
  endtask

  function automatic void push_prog1_once();
    push_issue(ADD); push_issue(SUB); push_issue(AND); push_issue(OR);
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset fu_op", 32'(fu_op), 0);
    chk("reset fu_en", 32'(fu_en), 0);
    chk("reset busy",  32'(busy),  0);
    chk("reset done",  32'(done),  0);
    chk("reset pc",    32'(pc),    0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    test_name = "iters1";
    load_prog1();
    go(1);
    push_prog1_once(); push_done(); push_idle();
    drain();

    test_name = "iters3";
    go(3);
    for (int k = 0; k < 3; k++) push_prog1_once();
    push_done(); push_idle(); push_idle();
    drain();

    test_name = "br_taken";
    wr(0, mk(BEQ, 1, 1, 0, 3));
    wr(1, mk(ADD, 1, 0, 1, 0));
    wr(2, mk(AND, 1, 0, 0, 0));
    wr(3, mk(OR,  1, 0, 1, 0));
    fu_branch = 1'b1;
    go(1);
    push_issue(BEQ); push_bubble(BEQ); push_issue(OR); push_done(); push_idle();
    drain();

    test_name = "br_not_taken";
    fu_branch = 1'b0;
    go(1);
    push_issue(BEQ); push_bubble(BEQ); push_issue(ADD); push_done(); push_idle();
    drain();

    test_name = "iters0";
    go(0);
    push_done(); push_idle();
    drain();

    test_name = "cfg_busy";
    load_prog1();
    go(1);
    push_prog1_once(); push_done(); push_idle();
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = mk(MULT, 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    cfg_we = 1'b0;
    drain();
    test_name = "cfg_busy_rerun";
    go(1);
    push_prog1_once(); push_done(); push_idle();
    drain();

    test_name = "abort";
    go(3);
    push_issue(ADD); push_skip(); push_idle(); push_idle();
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    drain();

    test_name = "mid_reset";
    go(3);
    push_issue(ADD); push_issue(SUB);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset fu_en", 32'(fu_en), 0);
    chk("mid_reset pc",    32'(pc),    0);
    chk("mid_reset busy",  32'(busy),  0);
    chk("mid_reset fu_op", 32'(fu_op), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drain();
    test_name = "after_reset";
    go(1);
    push_prog1_once(); push_done(); push_idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fu_seq.md
# fu_seq

Context sequencer that drives one CGRA functional unit. It holds a small context memory of per-cycle instructions and, once started, issues one context per cycle on the FU's `op`/`en` inputs. It uses the FU's registered `branch_out` to take data-dependent jumps, and repeats the context program for a programmed number of iterations. It sits between the configuration loader and each `fu` instance, as the issuing end of the FU's `op`/`en`/`branch_out` interface.

## Interface
- DEPTH, 16, number of context entries (power of two, 2..256)
- AW, 4, log2(DEPTH); width of pc, cfg_addr and the context target field
- ITER_W, 16, width of the iteration count
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  context write strobe; honoured only in IDLE
- cfg_addr  in  AW  context entry written
- cfg_data  in  8+AW  context word: [3:0] op, [4] en, [5] brc, [6] last, [7] reserved (write 0), [8+AW-1:8] target
- start  in  1  start request; honoured only in IDLE
- iters  in  ITER_W  iteration count, sampled with start
- abort  in  1  synchronous stop; returns to IDLE with no done
- fu_branch  in  1  connected to the FU's branch_out
- fu_op  out  4  to the FU's op
- fu_en  out  1  to the FU's en
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- pc  out  AW  current context index, for debug

## Operation
- States: IDLE, RUN, BWAIT. The context memory and `iter_cnt` are flops. Context memory contents are not reset; the bench writes every entry before use.
- IDLE:
  - fu_en=0, fu_op=0.
  - cfg_we writes cfg_data to ctx[cfg_addr].
  - start with iters!=0: pc←0, iter_cnt←iters, go to RUN.
  - start with iters==0: done pulses next cycle; stay in IDLE.
- RUN, with w=ctx[pc]:
  - Outputs, combinational from w: fu_op=w.op, fu_en=w.en.
  - If w.brc: go to BWAIT, pc held.
  - Else if w.last: if iter_cnt==1, go to IDLE with done; otherwise iter_cnt−1 and pc←0.
  - Else pc←pc+1. pc wraps modulo DEPTH.
- BWAIT (one bubble; the FU registers branch_out one cycle after issue):
  - fu_en=0, fu_op=w.op.
  - fu_branch=1: pc←w.target, go to RUN. A taken branch overrides last and does not decrement iter_cnt.
  - fu_branch=0: apply the RUN last/increment rule, then go to RUN or IDLE.
- abort in any state: go to IDLE, fu_en=0, no done. abort has priority over start and over the done transition.
- cfg_we while busy: ignored; memory unchanged.
- start while busy: ignored.

## Timing
- Reset values: state=IDLE, pc=0, iter_cnt=0, fu_op=0, fu_en=0, busy=0, done=0.
- Issue latency: the context at pc=0 appears on fu_op/fu_en in the first cycle after the start edge.
- Throughput: one context per cycle; each brc context costs 2 cycles.
- done is registered. It is high for exactly one cycle, the first IDLE cycle after the final last context (or the cycle after start with iters==0). busy is already 0 in that cycle.
- fu_branch is sampled only on BWAIT edges and ignored elsewhere.
- rst_n asserted mid-run: immediate return to IDLE/reset values, independent of clk. Context memory is preserved.

## Structure
- Package `fu_pkg`:
  - FU opcode localparams: PASS_A=0, PASS_B=1, ADD=2, SUB=3, MULT=4, DIV=5, AND=6, OR=7, MOD=8, SHL=9, SHR=10, BEQ=11, BNE=12, SLT=13, NOT=14, MERGE=15.
  - Context field offsets: OP, EN, BRC, LAST, TGT.
  - State encoding: IDLE/RUN/BWAIT.
- Sub-module `fu_ctx_mem`: DEPTH×(8+AW) flop array, one synchronous write port, one asynchronous read port.
- Everything else lives in `fu_seq`.

## Test plan
- Reset, then 4 contexts ADD/SUB/AND/OR(last), en=1, iters=1, start → fu_op 2,3,6,7 on consecutive cycles with fu_en=1; done one cycle later; busy low.
- Same program, iters=3 → op sequence repeated 3 times (12 issue cycles); exactly one done pulse.
- ctx0=BEQ brc target=3; ctx1 ADD last; ctx3 OR last; iters=1:
  - fu_branch=1 in BWAIT → issues 11, bubble (en=0), 7, then done.
  - fu_branch=0 → issues 11, bubble, 2, then done.
- start with iters=0 → done high for one cycle; fu_en never asserted.
- Mid-run cases:
  - cfg_we to ctx1 while busy → memory unchanged; rerun shows the original op.
  - abort at cycle 2 → IDLE next cycle, done stays 0.
- rst_n low for one cycle mid-run → fu_en=0, pc=0 immediately.
  - Context memory retained: a fresh start reproduces the program.
